// File: rtl/axis_video_frame_monitor.sv
// Passive AXI4-Stream video monitor: checks line length, frame height and SOF
// framing on a tapped stream and reports a per-frame pixel checksum.
module axis_video_frame_monitor #(
    parameter int IMAGE_WIDTH     = 512,
    parameter int IMAGE_HEIGHT    = 768,
    parameter int PIXEL_WIDTH     = 8,
    parameter int PIXELS_PER_BEAT = 1,
    parameter int CNT_WIDTH       = 16,
    localparam int BEATS_PER_LINE = IMAGE_WIDTH / PIXELS_PER_BEAT,
    localparam int BW             = $clog2(BEATS_PER_LINE + 1)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [PIXEL_WIDTH*PIXELS_PER_BEAT-1:0] axis_tdata,
    input  logic                                   axis_tvalid,
    input  logic                                   axis_tready,
    input  logic                                   axis_tlast,
    input  logic                                   axis_tuser,
    input  logic                                   clear,
    output logic                                   frame_done,
    output logic [31:0]                            frame_checksum,
    output logic [CNT_WIDTH-1:0]                   frame_count,
    output logic                                   line_err,
    output logic [BW-1:0]                          err_line_len,
    output logic [2:0]                             err_sticky,
    output logic [CNT_WIDTH-1:0]                   err_count
);
    localparam int LW = $clog2(IMAGE_HEIGHT + 1);

    typedef enum logic {WAIT_SOF, IN_FRAME} state_t;

    state_t                 state_q;
    logic [BW-1:0]          bcnt_q;
    logic [LW-1:0]          lcnt_q;
    logic [31:0]            acc_q;
    logic                   frame_err_q;
    logic                   frame_done_q;
    logic [31:0]            frame_checksum_q;
    logic [CNT_WIDTH-1:0]   frame_count_q;
    logic                   line_err_q;
    logic [BW-1:0]          err_line_len_q;
    logic [2:0]             err_sticky_q, err_sticky_d;
    logic [CNT_WIDTH-1:0]   err_count_q, err_count_d;

    // Lanes summed at 32 bits: identical to a full-width sum truncated mod 2^32.
    logic [31:0] lane_w [PIXELS_PER_BEAT];
    logic [31:0] beat_sum;

    generate
        for (genvar gi = 0; gi < PIXELS_PER_BEAT; gi++) begin : g_lane
            assign lane_w[gi] = 32'(axis_tdata[gi*PIXEL_WIDTH +: PIXEL_WIDTH]);
        end
    endgenerate

    logic          accept, restart, early_sof, orphan, track;
    logic [BW-1:0] base_b, beats;
    logic [LW-1:0] base_l;
    logic [31:0]   base_acc, acc_sum;
    logic          base_err, line_end, len_bad, frame_end, frame_bad;
    logic [2:0]    err_bits;

    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < PIXELS_PER_BEAT; i++) begin
            beat_sum = beat_sum + lane_w[i];
        end
        accept    = axis_tvalid && axis_tready;
        // A SOF beat starts a fresh frame unless it is exactly where one is expected.
        restart   = accept && axis_tuser &&
                    (state_q == WAIT_SOF || bcnt_q != '0 || lcnt_q != '0);
        early_sof = restart && (state_q == IN_FRAME);
        orphan    = accept && (state_q == WAIT_SOF) && !axis_tuser;
        track     = accept && (state_q == IN_FRAME || axis_tuser);
        base_b    = restart ? '0 : bcnt_q;
        base_l    = restart ? '0 : lcnt_q;
        base_acc  = restart ? '0 : acc_q;
        base_err  = restart ? 1'b0 : frame_err_q;
        beats     = base_b + BW'(1);
        acc_sum   = base_acc + beat_sum;
        line_end  = axis_tlast || (beats == BW'(BEATS_PER_LINE));
        len_bad   = line_end && !(axis_tlast && beats == BW'(BEATS_PER_LINE));
        frame_end = line_end && (base_l == LW'(IMAGE_HEIGHT - 1));
        frame_bad = base_err || len_bad;
        err_bits  = {orphan, early_sof, track && len_bad};

        // Clear acts first so an error in the same cycle survives on its own.
        err_sticky_d = clear ? 3'b000 : err_sticky_q;
        err_count_d  = clear ? '0 : err_count_q;
        if (|err_bits) begin
            err_sticky_d = err_sticky_d | err_bits;
            if (err_count_d != '1) begin
                err_count_d = err_count_d + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= WAIT_SOF;
            bcnt_q           <= '0;
            lcnt_q           <= '0;
            acc_q            <= '0;
            frame_err_q      <= 1'b0;
            frame_done_q     <= 1'b0;
            frame_checksum_q <= '0;
            frame_count_q    <= '0;
            line_err_q       <= 1'b0;
            err_line_len_q   <= '0;
            err_sticky_q     <= 3'b000;
            err_count_q      <= '0;
        end else begin
            frame_done_q <= 1'b0;
            line_err_q   <= 1'b0;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
            if (track) begin
                state_q     <= IN_FRAME;
                acc_q       <= acc_sum;
                frame_err_q <= frame_bad;
                bcnt_q      <= line_end ? '0 : beats;
                lcnt_q      <= line_end ? base_l + LW'(1) : base_l;
                if (len_bad) begin
                    line_err_q     <= 1'b1;
                    err_line_len_q <= beats;
                end
                if (frame_end) begin
                    state_q     <= WAIT_SOF;
                    acc_q       <= '0;
                    bcnt_q      <= '0;
                    lcnt_q      <= '0;
                    frame_err_q <= 1'b0;
                    if (!frame_bad) begin
                        frame_done_q     <= 1'b1;
                        frame_checksum_q <= acc_sum;
                        frame_count_q    <= frame_count_q + CNT_WIDTH'(1);
                    end
                end
            end
        end
    end

    assign frame_done     = frame_done_q;
    assign frame_checksum = frame_checksum_q;
    assign frame_count    = frame_count_q;
    assign line_err       = line_err_q;
    assign err_line_len   = err_line_len_q;
    assign err_sticky     = err_sticky_q;
    assign err_count      = err_count_q;
endmodule

// File: tb/tb_axis_video_frame_monitor.sv
// Two monitors (1 and 2 pixels per beat, 4x3 image) watch one shared stream and
// are checked every cycle against a frame-level reference model.
module tb_axis_video_frame_monitor;
    localparam int H = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic [15:0] tdata = '0;
    logic        tvalid = 1'b0, tready = 1'b0, tlast = 1'b0, tuser = 1'b0;

    always #5 clk = ~clk;

    logic        a_done, a_lerr, b_done, b_lerr;
    logic [2:0]  a_elen, a_st, b_st;
    logic [1:0]  b_elen;
    logic [31:0] a_cks, b_cks;
    logic [15:0] a_fc, a_ec, b_fc, b_ec;

    axis_video_frame_monitor #(
        .IMAGE_WIDTH(4), .IMAGE_HEIGHT(H), .PIXEL_WIDTH(8),
        .PIXELS_PER_BEAT(1), .CNT_WIDTH(16)
    ) dut_a (
        .clk(clk), .rst(rst), .axis_tdata(tdata[7:0]), .axis_tvalid(tvalid),
        .axis_tready(tready), .axis_tlast(tlast), .axis_tuser(tuser), .clear(clear),
        .frame_done(a_done), .frame_checksum(a_cks), .frame_count(a_fc),
        .line_err(a_lerr), .err_line_len(a_elen), .err_sticky(a_st), .err_count(a_ec)
    );

    axis_video_frame_monitor #(
        .IMAGE_WIDTH(4), .IMAGE_HEIGHT(H), .PIXEL_WIDTH(8),
        .PIXELS_PER_BEAT(2), .CNT_WIDTH(16)
    ) dut_b (
        .clk(clk), .rst(rst), .axis_tdata(tdata), .axis_tvalid(tvalid),
        .axis_tready(tready), .axis_tlast(tlast), .axis_tuser(tuser), .clear(clear),
        .frame_done(b_done), .frame_checksum(b_cks), .frame_count(b_fc),
        .line_err(b_lerr), .err_line_len(b_elen), .err_sticky(b_st), .err_count(b_ec)
    );

    int total = 0;
    int bad   = 0;

    // Expected observable outputs plus the frame progress they depend on.
    typedef struct {
        bit        in_f;
        int        b;
        int        l;
        bit [31:0] acc;
        bit        tainted;
        bit [31:0] cks;
        int        fc;
        bit        done;
        bit        lerr;
        int        elen;
        bit [2:0]  st;
        int        ec;
    } mstate_t;

    mstate_t ma, mb;

    function automatic mstate_t mreset();
        mstate_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic mstate_t mstep(mstate_t s, bit acc_beat, bit [31:0] bsum,
                                      bit u, bit lst, bit clr, int bpl, int h);
        bit [2:0] ev = 3'b000;
        s.done = 0;
        s.lerr = 0;
        if (clr) begin
            s.st = 0;
            s.ec = 0;
        end
        if (acc_beat) begin
            if (!s.in_f && !u) begin
                ev[2] = 1;
            end else begin
                if (u && !(s.in_f && s.b == 0 && s.l == 0)) begin
                    if (s.in_f) ev[1] = 1;
                    s.in_f = 1; s.b = 0; s.l = 0; s.acc = 0; s.tainted = 0;
                end
                s.acc = s.acc + bsum;
                s.b++;
                if (lst || s.b == bpl) begin
                    if (!(lst && s.b == bpl)) begin
                        s.lerr = 1; s.elen = s.b; ev[0] = 1; s.tainted = 1;
                    end
                    s.b = 0;
                    s.l++;
                    if (s.l == h) begin
                        if (!s.tainted) begin
                            s.cks = s.acc; s.done = 1; s.fc = (s.fc + 1) % 65536;
                        end
                        s.in_f = 0; s.l = 0; s.acc = 0; s.tainted = 0;
                    end
                end
            end
        end
        if (ev != 0) begin
            s.st = s.st | ev;
            s.ec = (s.ec >= 65535) ? 65535 : s.ec + 1;
        end
        return s;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            ma <= mreset();
            mb <= mreset();
        end else begin
            ma <= mstep(ma, tvalid && tready, 32'(tdata[7:0]), tuser, tlast, clear, 4, H);
            mb <= mstep(mb, tvalid && tready, 32'(tdata[7:0]) + 32'(tdata[15:8]),
                        tuser, tlast, clear, 2, H);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_dut(input string tag, input mstate_t m, input logic done,
                           input logic lerr, input logic [63:0] elen, input logic [2:0] st,
                           input logic [63:0] ec, input logic [63:0] fc,
                           input logic [31:0] cks);
        chk({tag, ".frame_done"}, 64'(done), 64'(m.done));
        chk({tag, ".line_err"}, 64'(lerr), 64'(m.lerr));
        chk({tag, ".err_line_len"}, elen, 64'(m.elen));
        chk({tag, ".err_sticky"}, 64'(st), 64'(m.st));
        chk({tag, ".err_count"}, ec, 64'(m.ec));
        chk({tag, ".frame_count"}, fc, 64'(m.fc));
        chk({tag, ".frame_checksum"}, 64'(cks), 64'(m.cks));
    endtask

    always @(negedge clk) begin
        chk_dut("a", ma, a_done, a_lerr, 64'(a_elen), a_st, 64'(a_ec), 64'(a_fc), a_cks);
        chk_dut("b", mb, b_done, b_lerr, 64'(b_elen), b_st, 64'(b_ec), 64'(b_fc), b_cks);
    end

    // Pins both the DUT and the model to a hand-computed value.
    task automatic lit(input string nm, input logic [63:0] dv, input logic [63:0] mv,
                       input logic [63:0] want);
        chk({nm, " dut"}, dv, want);
        chk({nm, " model"}, mv, want);
    endtask

    task automatic send(input logic [15:0] d, input logic u, input logic l, input bit stalls);
        if (stalls) begin
            repeat ($urandom_range(0, 2)) begin
                int r;
                r = $urandom_range(0, 2);
                tvalid = (r == 1);
                tready = (r == 2);
                tdata  = 16'($urandom);
                tuser  = 1'($urandom);
                tlast  = 1'($urandom);
                @(posedge clk);
                #1;
            end
        end
        tvalid = 1'b1;
        tready = 1'b1;
        tdata  = d;
        tuser  = u;
        tlast  = l;
        $display("t=%0t beat data=%h user=%b last=%b clear=%b", $time, d, u, l, clear);
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        tready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic frame_a(input bit ff, input bit stalls);
        for (int i = 0; i < 12; i++) begin
            send(ff ? 16'h00FF : 16'(i), i == 0, (i % 4) == 3, stalls);
        end
    endtask

    initial begin
        do_reset();
        lit("reset a.frame_done", 64'(a_done), 64'(ma.done), 0);
        lit("reset a.line_err", 64'(a_lerr), 64'(ma.lerr), 0);
        lit("reset a.err_line_len", 64'(a_elen), 64'(ma.elen), 0);
        lit("reset a.frame_checksum", 64'(a_cks), 64'(ma.cks), 0);
        lit("reset a.frame_count", 64'(a_fc), 64'(ma.fc), 0);
        lit("reset a.err_sticky", 64'(a_st), 64'(ma.st), 0);
        lit("reset b.err_count", 64'(b_ec), 64'(mb.ec), 0);

        // Clean 4x3 frame, pixels 0..11.
        frame_a(0, 0);
        lit("s1 frame_done", 64'(a_done), 64'(ma.done), 1);
        lit("s1 checksum", 64'(a_cks), 64'(ma.cks), 66);
        lit("s1 frame_count", 64'(a_fc), 64'(ma.fc), 1);
        lit("s1 err_sticky", 64'(a_st), 64'(ma.st), 0);

        // Stalled frame then an all-0xFF frame back to back.
        do_reset();
        frame_a(0, 1);
        lit("s2 checksum1", 64'(a_cks), 64'(ma.cks), 66);
        lit("s2 frame_count1", 64'(a_fc), 64'(ma.fc), 1);
        frame_a(1, 0);
        lit("s2 frame_done2", 64'(a_done), 64'(ma.done), 1);
        lit("s2 checksum2", 64'(a_cks), 64'(ma.cks), 3060);
        lit("s2 frame_count2", 64'(a_fc), 64'(ma.fc), 2);

        // Two pixels per beat: line 1 ends on its first beat.
        do_reset();
        send(16'h0100, 1, 0, 0);
        send(16'h0302, 0, 1, 0);
        send(16'h0504, 0, 1, 0);
        lit("s3 line_err", 64'(b_lerr), 64'(mb.lerr), 1);
        lit("s3 err_line_len", 64'(b_elen), 64'(mb.elen), 1);
        lit("s3 err_sticky", 64'(b_st), 64'(mb.st), 1);
        send(16'h0706, 0, 0, 0);
        send(16'h0908, 0, 1, 0);
        lit("s3 frame_done", 64'(b_done), 64'(mb.done), 0);
        lit("s3 frame_count", 64'(b_fc), 64'(mb.fc), 0);
        lit("s3 checksum", 64'(b_cks), 64'(mb.cks), 0);

        // Missing tlast on line 0.
        do_reset();
        for (int i = 0; i < 4; i++) send(16'(i), i == 0, 0, 0);
        lit("s4 line_err", 64'(a_lerr), 64'(ma.lerr), 1);
        lit("s4 err_line_len", 64'(a_elen), 64'(ma.elen), 4);
        for (int i = 4; i < 8; i++) send(16'(i), 0, i == 7, 0);
        lit("s4 line1 ok", 64'(a_lerr), 64'(ma.lerr), 0);
        lit("s4 err_count", 64'(a_ec), 64'(ma.ec), 1);
        for (int i = 8; i < 12; i++) send(16'(i), 0, i == 11, 0);
        lit("s4 frame_done", 64'(a_done), 64'(ma.done), 0);
        lit("s4 frame_count", 64'(a_fc), 64'(ma.fc), 0);

        // Early SOF at line 1 beat 2; the new frame holds pixels 1..12.
        do_reset();
        for (int i = 0; i < 6; i++) send(16'd100, i == 0, i == 3, 0);
        send(16'd1, 1, 0, 0);
        lit("s5 err_sticky", 64'(a_st), 64'(ma.st), 2);
        lit("s5 err_count", 64'(a_ec), 64'(ma.ec), 1);
        for (int k = 1; k < 12; k++) send(16'(k + 1), 0, (k % 4) == 3, 0);
        lit("s5 frame_done", 64'(a_done), 64'(ma.done), 1);
        lit("s5 checksum", 64'(a_cks), 64'(ma.cks), 78);
        lit("s5 frame_count", 64'(a_fc), 64'(ma.fc), 1);

        // Data outside a frame, clear, clear colliding with an error, mid-frame reset.
        do_reset();
        send(16'd5, 0, 0, 0);
        send(16'd6, 0, 0, 0);
        lit("s6 err_sticky", 64'(a_st), 64'(ma.st), 4);
        lit("s6 err_count", 64'(a_ec), 64'(ma.ec), 2);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        lit("s6 cleared sticky", 64'(a_st), 64'(ma.st), 0);
        lit("s6 cleared count", 64'(a_ec), 64'(ma.ec), 0);
        clear = 1'b1;
        send(16'd7, 0, 0, 0);
        clear = 1'b0;
        lit("s6 clear+err sticky", 64'(a_st), 64'(ma.st), 4);
        lit("s6 clear+err count", 64'(a_ec), 64'(ma.ec), 1);
        for (int i = 0; i < 6; i++) send(16'(i), i == 0, (i % 4) == 3, 0);
        do_reset();
        lit("s6 rst sticky", 64'(a_st), 64'(ma.st), 0);
        lit("s6 rst count", 64'(a_ec), 64'(ma.ec), 0);
        lit("s6 rst checksum", 64'(a_cks), 64'(ma.cks), 0);
        frame_a(0, 0);
        lit("s6 frame_done", 64'(a_done), 64'(ma.done), 1);
        lit("s6 checksum", 64'(a_cks), 64'(ma.cks), 66);
        lit("s6 frame_count", 64'(a_fc), 64'(ma.fc), 1);

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
